// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register slave.
// Contents:
//   apb_state_e - bus-side FSM states (idle, setup, access)
//   WAIT_W      - width of the wait-state counter
//   addr_hit()  - true when a word index selects an implemented register
package apb_reg_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  function automatic logic addr_hit(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB slave.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   we_i            - commit request (one cycle, already qualified as a hit write)
//   waddr_i         - target register index
//   wdata_i         - data to merge
//   wmask_i         - per-bit update mask built from the byte-lane strobes
//   reg_q_o         - flattened register contents, register i at [i*DATA_W +: DATA_W]
//   wr_stb_o        - one-cycle pulse on register i the cycle after it is written
module apb_reg_bank #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W-1:0]          wmask_i,
  output logic [NUM_REGS*DATA_W-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]        wr_stb_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] stb_q, stb_d;

  // An all-zero mask is a write that touches nothing, so it raises no strobe either.
  always_comb begin
    regs_d = regs_q;
    stb_d  = '0;
    if (we_i && (|wmask_i)) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (waddr_i == ADDR_W'(i)) begin
          regs_d[i] = (regs_q[i] & ~wmask_i) | (wdata_i & wmask_i);
          stb_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
      stb_q  <= '0;
    end else begin
      regs_q <= regs_d;
      stb_q  <= stb_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_stb_o = stb_q;

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 slave exposing NUM_REGS read/write registers with programmable wait states.
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-low reset
//   addr              - word index of the target register
//   pwdata, pwrite    - write data, 1 = write / 0 = read
//   psel, penable     - APB select and access phase
//   pready, pslverr   - transfer complete, error response (valid with pready)
//   prdata            - read data (valid with pready on a read, 0 otherwise)
//   reg_q             - flattened register contents towards the fabric
//   wr_stb            - per-register write pulse, one cycle after the commit
// Build option:
//   APB_REG_STRB_EN   - adds pstrb (DATA_W/8 byte lanes); only enabled lanes are
//                       written, and a read with any lane enabled is an error.
// Requires 1 <= NUM_REGS <= 2**ADDR_W and WAIT_STATES <= 15.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic                       pwrite,
  input  logic                       psel,
  input  logic                       penable,
`ifdef APB_REG_STRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_W-1:0]          prdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_stb
);

  apb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
`ifdef APB_REG_STRB_EN
  logic [DATA_W/8-1:0] strb_q, strb_d;
`endif

  logic              hit, err, finish, commit;
  logic [DATA_W-1:0] rd_word, wmask;

  assign hit = addr_hit(32'(addr_q), NUM_REGS);

`ifdef APB_REG_STRB_EN
  assign err = !hit || (!write_q && (strb_q != '0));

  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      wmask[b*8 +: 8] = {8{strb_q[b]}};
    end
  end
`else
  assign err   = !hit;
  assign wmask = '1;
`endif

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        rd_word = reg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // finish: the next cycle is the pready cycle, so the response flops load now.
  // commit: this is the pready cycle; the bank updates on the closing edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
`ifdef APB_REG_STRB_EN
    strb_d  = strb_q;
`endif
    finish  = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // penable without a preceding setup cycle is not a transfer start.
        if (psel && !penable) begin
          state_d = StSetup;
          addr_d  = addr;
          write_d = pwrite;
          wdata_d = pwdata;
`ifdef APB_REG_STRB_EN
          strb_d  = pstrb;
`endif
        end
      end
      StSetup: begin
        if (!psel) begin
          state_d = StIdle;
        end else begin
          state_d = StAccess;
          cnt_d   = WAIT_W'(WAIT_STATES);
          finish  = (WAIT_STATES == 0);
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          commit  = write_q && !err;
        end else if (!psel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q - WAIT_W'(1);
          finish = (cnt_q == WAIT_W'(1));
        end
      end
      default: state_d = StIdle;
    endcase

    pready_d  = finish;
    pslverr_d = finish && err;
    prdata_d  = (finish && !write_q && !err) ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_REG_STRB_EN
      strb_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_REG_STRB_EN
      strb_q    <= strb_d;
`endif
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  apb_reg_bank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk_i    (clk),
    .rst_ni   (reset),
    .we_i     (commit),
    .waddr_i  (addr_q),
    .wdata_i  (wdata_q),
    .wmask_i  (wmask),
    .reg_q_o  (reg_q),
    .wr_stb_o (wr_stb)
  );

endmodule
